// File: rtl/tcp_rx_ctrl_fsm.sv
// Control FSM for the TCP receive datapath: one packet at a time through intake, flow lookup,
// state read, RX buffer malloc, calc/commit and write-back, with a separate SYN allocation path.
module tcp_rx_ctrl_fsm #(
    parameter int MALLOC_RETRY_MAX = 2,
    parameter int DROP_CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_hdr_val,
    output logic                  rx_hdr_rdy,
    input  logic                  rx_hdr_is_syn,
    input  logic                  rx_hdr_has_payload,
    input  logic                  read_flow_cam_hit,
    output logic                  flowid_mgr_req,
    input  logic                  flowid_mgr_avail,
    output logic                  state_rd_req_val,
    input  logic                  state_rd_req_rdy,
    input  logic                  state_rd_resp_val,
    output logic                  malloc_req_val,
    input  logic                  malloc_req_rdy,
    input  logic                  malloc_resp_val,
    input  logic                  malloc_resp_success,
    output logic                  state_wr_val,
    input  logic                  state_wr_rdy,
    output logic                  buf_store_wr_val,
    input  logic                  buf_store_wr_rdy,
    output logic                  sched_cmd_val,
    input  logic                  sched_cmd_rdy,
    output logic                  rx_dst_val,
    input  logic                  rx_dst_rdy,
    output logic                  new_flow_val,
    input  logic                  new_flow_rdy,
    output logic                  slow_path_enq_val,
    input  logic                  slow_path_enq_rdy,
    output logic                  app_new_flow_val,
    input  logic                  app_new_flow_rdy,
    output logic                  ctrl_datap_save_input,
    output logic                  ctrl_datap_save_flow_state,
    output logic                  ctrl_datap_save_malloc_resp,
    output logic                  ctrl_datap_save_calcs,
    output logic                  store_flowid_cam,
    output logic                  store_flowid_manager,
    input  logic                  datap_ctrl_payload_accepted,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int RETRY_W = (MALLOC_RETRY_MAX < 1) ? 1 : $clog2(MALLOC_RETRY_MAX + 1);

    typedef enum logic [3:0] {
        S_READY, S_LOOKUP, S_ALLOC, S_NEW_WB, S_RD_REQ,
        S_RD_RESP, S_MALLOC_REQ, S_MALLOC_RESP, S_CALC, S_WB
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_is_syn;
    logic                  r_has_payload;
    logic [RETRY_W-1:0]    r_retry;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_drop_inc;
    logic                  w_retry_inc;
    // Sticky per-channel done bits for the two multi-channel write-back states.
    logic                  r_nf_done, r_sp_done, r_app_done;
    logic                  r_sw_done, r_sc_done, r_bs_done, r_rd_done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        w_state_nxt                 = r_state;
        w_drop_inc                  = 1'b0;
        w_retry_inc                 = 1'b0;
        rx_hdr_rdy                  = 1'b0;
        flowid_mgr_req              = 1'b0;
        state_rd_req_val            = 1'b0;
        malloc_req_val              = 1'b0;
        state_wr_val                = 1'b0;
        buf_store_wr_val            = 1'b0;
        sched_cmd_val               = 1'b0;
        rx_dst_val                  = 1'b0;
        new_flow_val                = 1'b0;
        slow_path_enq_val           = 1'b0;
        app_new_flow_val            = 1'b0;
        ctrl_datap_save_input       = 1'b0;
        ctrl_datap_save_flow_state  = 1'b0;
        ctrl_datap_save_malloc_resp = 1'b0;
        ctrl_datap_save_calcs       = 1'b0;
        store_flowid_cam            = 1'b0;
        store_flowid_manager        = 1'b0;

        if (!rst) begin
            case (r_state)
                S_READY: begin
                    rx_hdr_rdy = 1'b1;
                    if (rx_hdr_val) begin
                        ctrl_datap_save_input = 1'b1;
                        w_state_nxt           = S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (read_flow_cam_hit && !r_is_syn) begin
                        store_flowid_cam = 1'b1;
                        w_state_nxt      = S_RD_REQ;
                    end else if (!read_flow_cam_hit && r_is_syn) begin
                        w_state_nxt = S_ALLOC;
                    end else begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = S_READY;
                    end
                end
                S_ALLOC: begin
                    flowid_mgr_req = 1'b1;
                    if (flowid_mgr_avail) begin
                        store_flowid_manager = 1'b1;
                        w_state_nxt          = S_NEW_WB;
                    end else begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = S_READY;
                    end
                end
                S_NEW_WB: begin
                    new_flow_val      = !r_nf_done;
                    slow_path_enq_val = !r_sp_done;
                    app_new_flow_val  = !r_app_done;
                    if ((r_nf_done || new_flow_rdy) && (r_sp_done || slow_path_enq_rdy) &&
                        (r_app_done || app_new_flow_rdy))
                        w_state_nxt = S_READY;
                end
                S_RD_REQ: begin
                    state_rd_req_val = 1'b1;
                    if (state_rd_req_rdy) w_state_nxt = S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (state_rd_resp_val) begin
                        ctrl_datap_save_flow_state = 1'b1;
                        w_state_nxt = r_has_payload ? S_MALLOC_REQ : S_CALC;
                    end
                end
                S_MALLOC_REQ: begin
                    malloc_req_val = 1'b1;
                    if (malloc_req_rdy) w_state_nxt = S_MALLOC_RESP;
                end
                S_MALLOC_RESP: begin
                    if (malloc_resp_val) begin
                        if (!malloc_resp_success && (r_retry < RETRY_W'(MALLOC_RETRY_MAX))) begin
                            w_retry_inc = 1'b1;
                            w_state_nxt = S_MALLOC_REQ;
                        end else begin
                            // Success, or failure with retries exhausted: the result is recorded either way.
                            ctrl_datap_save_malloc_resp = 1'b1;
                            w_state_nxt                 = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    ctrl_datap_save_calcs = 1'b1;
                    w_state_nxt           = S_WB;
                end
                S_WB: begin
                    state_wr_val     = !r_sw_done;
                    sched_cmd_val    = !r_sc_done;
                    buf_store_wr_val = datap_ctrl_payload_accepted && !r_bs_done;
                    rx_dst_val       = datap_ctrl_payload_accepted && !r_rd_done;
                    if ((r_sw_done || state_wr_rdy) && (r_sc_done || sched_cmd_rdy) &&
                        (!datap_ctrl_payload_accepted || r_bs_done || buf_store_wr_rdy) &&
                        (!datap_ctrl_payload_accepted || r_rd_done || rx_dst_rdy))
                        w_state_nxt = S_READY;
                end
                default: w_state_nxt = S_READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state       <= S_READY;
            r_is_syn      <= 1'b0;
            r_has_payload <= 1'b0;
            r_retry       <= '0;
            r_drop_cnt    <= '0;
            r_nf_done     <= 1'b0;
            r_sp_done     <= 1'b0;
            r_app_done    <= 1'b0;
            r_sw_done     <= 1'b0;
            r_sc_done     <= 1'b0;
            r_bs_done     <= 1'b0;
            r_rd_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (ctrl_datap_save_input) begin
                r_is_syn      <= rx_hdr_is_syn;
                r_has_payload <= rx_hdr_has_payload;
                r_retry       <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RETRY_W'(1);
            end
            if (w_drop_inc && (r_drop_cnt != {DROP_CNT_W{1'b1}}))
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            if (r_state == S_READY) begin
                r_nf_done  <= 1'b0;
                r_sp_done  <= 1'b0;
                r_app_done <= 1'b0;
                r_sw_done  <= 1'b0;
                r_sc_done  <= 1'b0;
                r_bs_done  <= 1'b0;
                r_rd_done  <= 1'b0;
            end else begin
                if (new_flow_val && new_flow_rdy)           r_nf_done  <= 1'b1;
                if (slow_path_enq_val && slow_path_enq_rdy) r_sp_done  <= 1'b1;
                if (app_new_flow_val && app_new_flow_rdy)   r_app_done <= 1'b1;
                if (state_wr_val && state_wr_rdy)           r_sw_done  <= 1'b1;
                if (sched_cmd_val && sched_cmd_rdy)         r_sc_done  <= 1'b1;
                if (buf_store_wr_val && buf_store_wr_rdy)   r_bs_done  <= 1'b1;
                if (rx_dst_val && rx_dst_rdy)               r_rd_done  <= 1'b1;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_tcp_rx_ctrl_fsm.sv
// Self-checking bench for tcp_rx_ctrl_fsm: directed latency/retry/new-flow/reset scenarios plus
// randomized packets checked against per-packet transaction counts derived from the packet kind.
module tb_tcp_rx_ctrl_fsm;
    localparam int MALLOC_RETRY_MAX = 2;
    localparam int DROP_CNT_W       = 16;

    logic clk = 1'b0;
    logic rst;
    logic rx_hdr_val, rx_hdr_rdy, rx_hdr_is_syn, rx_hdr_has_payload, read_flow_cam_hit;
    logic flowid_mgr_req, flowid_mgr_avail;
    logic state_rd_req_val, state_rd_req_rdy, state_rd_resp_val;
    logic malloc_req_val, malloc_req_rdy, malloc_resp_val, malloc_resp_success;
    logic state_wr_val, state_wr_rdy, buf_store_wr_val, buf_store_wr_rdy;
    logic sched_cmd_val, sched_cmd_rdy, rx_dst_val, rx_dst_rdy;
    logic new_flow_val, new_flow_rdy, slow_path_enq_val, slow_path_enq_rdy;
    logic app_new_flow_val, app_new_flow_rdy;
    logic ctrl_datap_save_input, ctrl_datap_save_flow_state, ctrl_datap_save_malloc_resp;
    logic ctrl_datap_save_calcs, store_flowid_cam, store_flowid_manager;
    logic datap_ctrl_payload_accepted;
    logic [DROP_CNT_W-1:0] drop_cnt;

    // Channel order: 0 rd_req, 1 malloc, 2 state_wr, 3 buf_store, 4 sched, 5 rx_dst, 6 new_flow, 7 slow_path, 8 app
    logic [8:0] rdy_v;
    wire  [8:0] val_v;
    // Strobe order: 0 save_input, 1 save_flow_state, 2 save_malloc_resp, 3 save_calcs, 4 store_cam, 5 store_mgr
    wire  [5:0] strb_v;

    assign {app_new_flow_rdy, slow_path_enq_rdy, new_flow_rdy, rx_dst_rdy, sched_cmd_rdy,
            buf_store_wr_rdy, state_wr_rdy, malloc_req_rdy, state_rd_req_rdy} = rdy_v;
    assign val_v = {app_new_flow_val, slow_path_enq_val, new_flow_val, rx_dst_val, sched_cmd_val,
                    buf_store_wr_val, state_wr_val, malloc_req_val, state_rd_req_val};
    assign strb_v = {store_flowid_manager, store_flowid_cam, ctrl_datap_save_calcs,
                     ctrl_datap_save_malloc_resp, ctrl_datap_save_flow_state, ctrl_datap_save_input};

    int n_vec = 0;
    int n_err = 0;
    int exp_drop = 0;
    logic [5:0] tr_strb [64];
    logic [8:0] tr_val  [64];

    tcp_rx_ctrl_fsm #(.MALLOC_RETRY_MAX(MALLOC_RETRY_MAX), .DROP_CNT_W(DROP_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rx_hdr_val(rx_hdr_val), .rx_hdr_rdy(rx_hdr_rdy),
        .rx_hdr_is_syn(rx_hdr_is_syn), .rx_hdr_has_payload(rx_hdr_has_payload),
        .read_flow_cam_hit(read_flow_cam_hit),
        .flowid_mgr_req(flowid_mgr_req), .flowid_mgr_avail(flowid_mgr_avail),
        .state_rd_req_val(state_rd_req_val), .state_rd_req_rdy(state_rd_req_rdy),
        .state_rd_resp_val(state_rd_resp_val),
        .malloc_req_val(malloc_req_val), .malloc_req_rdy(malloc_req_rdy),
        .malloc_resp_val(malloc_resp_val), .malloc_resp_success(malloc_resp_success),
        .state_wr_val(state_wr_val), .state_wr_rdy(state_wr_rdy),
        .buf_store_wr_val(buf_store_wr_val), .buf_store_wr_rdy(buf_store_wr_rdy),
        .sched_cmd_val(sched_cmd_val), .sched_cmd_rdy(sched_cmd_rdy),
        .rx_dst_val(rx_dst_val), .rx_dst_rdy(rx_dst_rdy),
        .new_flow_val(new_flow_val), .new_flow_rdy(new_flow_rdy),
        .slow_path_enq_val(slow_path_enq_val), .slow_path_enq_rdy(slow_path_enq_rdy),
        .app_new_flow_val(app_new_flow_val), .app_new_flow_rdy(app_new_flow_rdy),
        .ctrl_datap_save_input(ctrl_datap_save_input),
        .ctrl_datap_save_flow_state(ctrl_datap_save_flow_state),
        .ctrl_datap_save_malloc_resp(ctrl_datap_save_malloc_resp),
        .ctrl_datap_save_calcs(ctrl_datap_save_calcs),
        .store_flowid_cam(store_flowid_cam), .store_flowid_manager(store_flowid_manager),
        .datap_ctrl_payload_accepted(datap_ctrl_payload_accepted),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one packet with a transaction-level responder; compares per-channel totals to the model.
    task automatic run_packet(input bit syn, input bit hit, input bit pay, input bit avail,
                              input bit acc, input int nfail, input bit rnd, output int done_cyc);
        int hs [9];
        int st [6];
        int e_hs [9];
        int e_st [6];
        int mreq, m_idx, attempts;
        bit rd_pend, m_pend, taken, p_rd, p_al, dropped;
        logic [8:0] prev_pend;

        p_rd     = hit && !syn;
        p_al     = !hit && syn;
        dropped  = !p_rd && !(p_al && avail);
        attempts = ((nfail > MALLOC_RETRY_MAX) ? MALLOC_RETRY_MAX : nfail) + 1;
        e_hs[0] = int'(p_rd);
        e_hs[1] = (p_rd && pay) ? attempts : 0;
        e_hs[2] = int'(p_rd);
        e_hs[3] = int'(p_rd && acc);
        e_hs[4] = int'(p_rd);
        e_hs[5] = int'(p_rd && acc);
        for (int i = 6; i < 9; i++) e_hs[i] = int'(p_al && avail);
        e_st[0] = 1;
        e_st[1] = int'(p_rd);
        e_st[2] = int'(p_rd && pay);
        e_st[3] = int'(p_rd);
        e_st[4] = int'(p_rd);
        e_st[5] = int'(p_al && avail);
        if (dropped) exp_drop++;

        foreach (hs[i]) hs[i] = 0;
        foreach (st[i]) st[i] = 0;
        mreq = 0; m_idx = 0; rd_pend = 0; m_pend = 0; taken = 0; prev_pend = '0; done_cyc = -1;

        rx_hdr_is_syn               = syn;
        rx_hdr_has_payload          = pay;
        read_flow_cam_hit           = hit;
        flowid_mgr_avail            = avail;
        datap_ctrl_payload_accepted = acc;
        rx_hdr_val                  = 1'b1;

        for (int c = 0; c < 400; c++) begin
            rdy_v               = rnd ? 9'($urandom) : '1;
            state_rd_resp_val   = rd_pend && (!rnd || ($urandom_range(0, 2) != 0));
            malloc_resp_val     = m_pend && (!rnd || ($urandom_range(0, 2) != 0));
            malloc_resp_success = (m_idx >= nfail);
            @(negedge clk);
            if (taken && rx_hdr_rdy) begin
                done_cyc = c;
                break;
            end
            n_vec++;
            if ((prev_pend & ~val_v) != 0) begin
                n_err++;
                $display("FAIL val_dropped_without_rdy: cycle %0d vals %b pending %b", c, val_v, prev_pend);
            end
            prev_pend = val_v & ~rdy_v;
            for (int i = 0; i < 9; i++) if (val_v[i] && rdy_v[i]) hs[i]++;
            for (int i = 0; i < 6; i++) st[i] += int'(strb_v[i]);
            mreq += int'(flowid_mgr_req);
            if (c < 64) begin
                tr_strb[c] = strb_v;
                tr_val[c]  = val_v;
            end
            if (rx_hdr_val && rx_hdr_rdy) taken = 1;
            if (state_rd_resp_val) rd_pend = 0;
            if (val_v[0] && rdy_v[0]) rd_pend = 1;
            if (malloc_resp_val) begin
                m_pend = 0;
                m_idx++;
            end
            if (val_v[1] && rdy_v[1]) m_pend = 1;
            tick();
            if (taken) rx_hdr_val = 1'b0;
        end

        n_vec++;
        if (done_cyc < 0) begin
            n_err++;
            $display("FAIL packet_timeout: no return to READY within 400 cycles (syn=%0d hit=%0d)", syn, hit);
        end
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (hs[i] !== e_hs[i]) begin
                n_err++;
                $display("FAIL handshakes_ch%0d: got %0d expected %0d", i, hs[i], e_hs[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (st[i] !== e_st[i]) begin
                n_err++;
                $display("FAIL strobe_pulses_%0d: got %0d expected %0d", i, st[i], e_st[i]);
            end
        end
        n_vec++;
        if (mreq !== int'(p_al)) begin
            n_err++;
            $display("FAIL flowid_mgr_req_cycles: got %0d expected %0d", mreq, int'(p_al));
        end
        n_vec++;
        if (drop_cnt !== DROP_CNT_W'(exp_drop)) begin
            n_err++;
            $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, exp_drop);
        end
        rx_hdr_val        = 1'b0;
        state_rd_resp_val = 1'b0;
        malloc_resp_val   = 1'b0;
        rdy_v             = '1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_hdr_val = 0; rx_hdr_is_syn = 0; rx_hdr_has_payload = 0; read_flow_cam_hit = 0;
        flowid_mgr_avail = 0; state_rd_resp_val = 0; malloc_resp_val = 0; malloc_resp_success = 0;
        datap_ctrl_payload_accepted = 0; rdy_v = '1;
        repeat (2) tick();
        rx_hdr_val = 1'b1;
        @(negedge clk);
        n_vec += 5;
        if (rx_hdr_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rx_hdr_rdy: got %b expected 0", rx_hdr_rdy); end
        if (val_v !== 9'b0) begin n_err++; $display("FAIL reset_vals: got %b expected 0", val_v); end
        if (strb_v !== 6'b0) begin n_err++; $display("FAIL reset_strobes: got %b expected 0", strb_v); end
        if (flowid_mgr_req !== 1'b0) begin n_err++; $display("FAIL reset_mgr_req: got %b expected 0", flowid_mgr_req); end
        if (drop_cnt !== '0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        tick();
        rst = 1'b0;
        rx_hdr_val = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rx_hdr_rdy !== 1'b1) begin n_err++; $display("FAIL post_reset_rdy: got %b expected 1", rx_hdr_rdy); end
        tick();
    endtask

    task automatic test_hit_no_payload();
        int dc;
        logic [5:0] exp_s [6];
        exp_s = '{6'b000001, 6'b010000, 6'b000000, 6'b000010, 6'b001000, 6'b000000};
        run_packet(0, 1, 0, 0, 0, 0, 0, dc);
        n_vec++;
        if (dc !== 6) begin n_err++; $display("FAIL latency_ready_cycle: got %0d expected 6", dc); end
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if (tr_strb[c] !== exp_s[c]) begin
                n_err++;
                $display("FAIL latency_strobes_c%0d: got %b expected %b", c, tr_strb[c], exp_s[c]);
            end
        end
        n_vec += 2;
        if (tr_val[2] !== 9'b000000001) begin n_err++; $display("FAIL latency_rd_req: got %b expected 000000001", tr_val[2]); end
        if (tr_val[5] !== 9'b000010100) begin n_err++; $display("FAIL latency_wb_vals: got %b expected 000010100", tr_val[5]); end
    endtask

    task automatic test_malloc(input int nfail, input bit acc, input logic [8:0] exp_wb);
        int dc;
        run_packet(0, 1, 1, 0, acc, nfail, 0, dc);
        n_vec += 3;
        if (dc !== 12) begin n_err++; $display("FAIL malloc_ready_cycle: got %0d expected 12", dc); end
        if (tr_strb[9] !== 6'b000100) begin n_err++; $display("FAIL malloc_save_resp_c9: got %b expected 000100", tr_strb[9]); end
        if (tr_val[11] !== exp_wb) begin n_err++; $display("FAIL malloc_wb_vals: got %b expected %b", tr_val[11], exp_wb); end
    endtask

    task automatic test_new_flow_stagger();
        rx_hdr_is_syn = 1; read_flow_cam_hit = 0; flowid_mgr_avail = 1; rx_hdr_has_payload = 0;
        rx_hdr_val = 1; rdy_v = '1; rdy_v[8:6] = 3'b000;
        @(negedge clk);
        n_vec++;
        if (rx_hdr_rdy !== 1'b1) begin n_err++; $display("FAIL nf_intake_rdy: got %b expected 1", rx_hdr_rdy); end
        tick();
        rx_hdr_val = 0;
        tick();
        @(negedge clk);
        n_vec++;
        if ({flowid_mgr_req, store_flowid_manager} !== 2'b11) begin
            n_err++;
            $display("FAIL nf_alloc: got %b expected 11", {flowid_mgr_req, store_flowid_manager});
        end
        tick();
        for (int k = 0; k <= 6; k++) begin
            logic [2:0] exp_v;
            rdy_v[6] = 1'b1;
            rdy_v[7] = (k >= 2);
            rdy_v[8] = (k >= 5);
            exp_v = {k <= 5, k <= 2, k <= 0};
            @(negedge clk);
            n_vec += 2;
            if (val_v[8:6] !== exp_v) begin
                n_err++;
                $display("FAIL nf_vals_k%0d: got %b expected %b", k, val_v[8:6], exp_v);
            end
            if (rx_hdr_rdy !== (k == 6)) begin
                n_err++;
                $display("FAIL nf_ready_k%0d: got %b expected %b", k, rx_hdr_rdy, (k == 6));
            end
            tick();
        end
        rdy_v = '1;
    endtask

    task automatic test_drops();
        int dc;
        run_packet(0, 0, 0, 1, 0, 0, 0, dc);
        run_packet(1, 1, 0, 1, 0, 0, 0, dc);
        run_packet(1, 0, 0, 0, 0, 0, 0, dc);
        n_vec += 2;
        if (dc !== 3) begin n_err++; $display("FAIL drop_alloc_ready_cycle: got %0d expected 3", dc); end
        if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL drop_cnt_total: got %0d expected 3", drop_cnt); end
    endtask

    task automatic test_reset_mid_wb();
        rx_hdr_is_syn = 0; read_flow_cam_hit = 1; rx_hdr_has_payload = 0; datap_ctrl_payload_accepted = 1;
        rdy_v = '1; rdy_v[2] = 1'b0; state_rd_resp_val = 1; rx_hdr_val = 1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 5) begin
                n_vec++;
                if (val_v !== 9'b000111100) begin n_err++; $display("FAIL rst_wb_entry_vals: got %b expected 000111100", val_v); end
            end
            if (c == 6) begin
                n_vec++;
                if (val_v !== 9'b000000100) begin n_err++; $display("FAIL rst_wb_hold_vals: got %b expected 000000100", val_v); end
            end
            tick();
            rx_hdr_val = 0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rx_hdr_rdy !== 1'b0) begin n_err++; $display("FAIL rst_cycle_rdy: got %b expected 0", rx_hdr_rdy); end
        tick();
        rst = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        n_vec += 3;
        if (val_v !== 9'b0) begin n_err++; $display("FAIL rst_after_vals: got %b expected 0", val_v); end
        if (rx_hdr_rdy !== 1'b1) begin n_err++; $display("FAIL rst_after_rdy: got %b expected 1", rx_hdr_rdy); end
        if (drop_cnt !== '0) begin n_err++; $display("FAIL rst_after_drop_cnt: got %0d expected 0", drop_cnt); end
        tick();
        state_rd_resp_val = 0;
        rdy_v = '1;
    endtask

    task automatic test_random();
        int dc, kind, nfail;
        bit syn, hit, pay, avail, acc;
        for (int p = 0; p < 40; p++) begin
            kind  = $urandom_range(0, 9);
            syn   = (kind >= 6 && kind != 8);
            hit   = (kind <= 5) || (kind == 9);
            pay   = $urandom_range(0, 1);
            avail = ($urandom_range(0, 3) != 0);
            acc   = $urandom_range(0, 1);
            nfail = $urandom_range(0, 4);
            run_packet(syn, hit, pay, avail, acc, nfail, 1, dc);
        end
    endtask

    initial begin
        test_reset();
        test_hit_no_payload();
        test_malloc(2, 1'b1, 9'b000111100);
        test_malloc(3, 1'b0, 9'b000010100);
        test_new_flow_stagger();
        test_drops();
        test_reset_mid_wb();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
